// File: rtl/cordic_pkg.sv
// Shared definitions for the rotational CORDIC scheduler: Q14.14 word type,
// angle constants, scheduler FSM states and the 1/K gain-compensation helper.
// No ports (package).
package cordic_pkg;

  localparam int unsigned WordLength  = 28;
  localparam int unsigned N           = 32;
  // Engine start-sample to valid XN/YN/ThetaN.
  localparam int unsigned ENG_LATENCY = N + 2;

  typedef logic signed [WordLength-1:0] q14_t;

  localparam q14_t PI_Q       = 28'sd51472;
  localparam q14_t HALF_PI_Q  = 28'sd25736;
  localparam q14_t INV_GAIN_Q = 28'sd9949;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  // Multiply by 1/K in Q14.14: full 56-bit signed product, arithmetic shift by
  // the fraction width, truncate back to a word.
  function automatic logic [WordLength-1:0] q14_scale(input logic [WordLength-1:0] v);
    logic signed [2*WordLength-1:0] a;
    logic signed [2*WordLength-1:0] b;
    logic signed [2*WordLength-1:0] p;
    a = {{WordLength{v[WordLength-1]}}, v};
    b = {{WordLength{1'b0}}, INV_GAIN_Q};
    p = a * b;
    return WordLength'(p >>> 14);
  endfunction

endpackage

// File: rtl/cordic_quad_prerot.sv
// Quadrant pre-rotation: folds |theta| > pi/2 into the engine convergence range
// by rotating the vector by pi (negate x and y) and offsetting theta by pi.
// Ports:
//   x, y, theta             - Q14.14 input vector and angle
//   x_rot, y_rot, theta_rot - folded vector and angle
// Negating -2^27 wraps to itself; inputs are expected well inside the range.
module cordic_quad_prerot
  import cordic_pkg::*;
(
  input  logic [WordLength-1:0] x,
  input  logic [WordLength-1:0] y,
  input  logic [WordLength-1:0] theta,
  output logic [WordLength-1:0] x_rot,
  output logic [WordLength-1:0] y_rot,
  output logic [WordLength-1:0] theta_rot
);

  q14_t th_s;

  always_comb begin
    th_s      = theta;
    x_rot     = x;
    y_rot     = y;
    theta_rot = theta;
    if (th_s > HALF_PI_Q) begin
      x_rot     = -x;
      y_rot     = -y;
      theta_rot = th_s - PI_Q;
    end else if (th_s < -HALF_PI_Q) begin
      x_rot     = -x;
      y_rot     = -y;
      theta_rot = th_s + PI_Q;
    end
  end

endmodule

// File: rtl/cordic_rot_sched.sv
// Two-requester scheduler for one shared iterative rotational CORDIC engine.
// Round-robin grant, quadrant pre-rotation, one-cycle engine start, fixed
// latency wait, then the result is held on a backpressured response channel.
// Ports:
//   clock, Reset                  - clock, synchronous active-high reset
//   req_valid/req_ready           - per-requester handshake (bit r = requester r)
//   req_x/req_y/req_theta         - packed operands, requester r at [r*W +: W]
//   resp_valid/resp_ready/resp_id - response handshake and requester tag
//   resp_x/resp_y/resp_theta      - rotated vector and residual angle
//   eng_start, eng_x0/y0/theta0   - engine start pulse and operands
//   eng_xn/eng_yn/eng_thetan      - engine results
// Build option CORDIC_GAIN_COMP_EN: scale resp_x/resp_y by 1/K at capture,
// which costs one extra cycle before resp_valid.
module cordic_rot_sched
  import cordic_pkg::*;
(
  input  logic                    clock,
  input  logic                    Reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*WordLength-1:0] req_x,
  input  logic [2*WordLength-1:0] req_y,
  input  logic [2*WordLength-1:0] req_theta,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_id,
  output logic [WordLength-1:0]   resp_x,
  output logic [WordLength-1:0]   resp_y,
  output logic [WordLength-1:0]   resp_theta,
  output logic                    eng_start,
  output logic [WordLength-1:0]   eng_x0,
  output logic [WordLength-1:0]   eng_y0,
  output logic [WordLength-1:0]   eng_theta0,
  input  logic [WordLength-1:0]   eng_xn,
  input  logic [WordLength-1:0]   eng_yn,
  input  logic [WordLength-1:0]   eng_thetan
);

  localparam int unsigned     CntW    = $clog2(ENG_LATENCY);
  localparam logic [CntW-1:0] CntLoad = CntW'(ENG_LATENCY - 1);

  state_e                state_q, state_d;
  logic                  ptr_q;
  logic                  id_q;
  logic [CntW-1:0]       cnt_q;
  logic                  any_req;
  logic                  gnt_id;
  logic                  wait_done;
  logic [WordLength-1:0] sel_x, sel_y, sel_theta;
  logic [WordLength-1:0] pr_x, pr_y, pr_theta;

`ifdef CORDIC_GAIN_COMP_EN
  logic                  pipe_q;
  logic [WordLength-1:0] raw_x_q, raw_y_q, raw_t_q;
  assign wait_done = pipe_q;
`else
  assign wait_done = (cnt_q == '0);
`endif

  // Pointer only matters on a tie; a lone request always wins.
  always_comb begin
    any_req   = |req_valid;
    gnt_id    = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    sel_x     = gnt_id ? req_x[2*WordLength-1:WordLength]     : req_x[WordLength-1:0];
    sel_y     = gnt_id ? req_y[2*WordLength-1:WordLength]     : req_y[WordLength-1:0];
    sel_theta = gnt_id ? req_theta[2*WordLength-1:WordLength] : req_theta[WordLength-1:0];
  end

  cordic_quad_prerot u_prerot (
    .x         (sel_x),
    .y         (sel_y),
    .theta     (sel_theta),
    .x_rot     (pr_x),
    .y_rot     (pr_y),
    .theta_rot (pr_theta)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_done) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore/Mealy outputs.
  always_comb begin
    req_ready = 2'b00;
    eng_start = 1'b0;
    if (state_q == IDLE && any_req) req_ready[gnt_id] = 1'b1;
    if (state_q == ISSUE) eng_start = 1'b1;
  end

  // Datapath: operand capture, wait counter, result capture.
  always_ff @(posedge clock) begin
    if (Reset) begin
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      eng_x0     <= '0;
      eng_y0     <= '0;
      eng_theta0 <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_x     <= '0;
      resp_y     <= '0;
      resp_theta <= '0;
`ifdef CORDIC_GAIN_COMP_EN
      pipe_q     <= 1'b0;
      raw_x_q    <= '0;
      raw_y_q    <= '0;
      raw_t_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            eng_x0     <= pr_x;
            eng_y0     <= pr_y;
            eng_theta0 <= pr_theta;
            id_q       <= gnt_id;
            ptr_q      <= ~gnt_id;
          end
        end
        ISSUE: cnt_q <= CntLoad;
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
          end else if (!pipe_q) begin
            raw_x_q <= eng_xn;
            raw_y_q <= eng_yn;
            raw_t_q <= eng_thetan;
            pipe_q  <= 1'b1;
          end else begin
            pipe_q     <= 1'b0;
            resp_x     <= q14_scale(raw_x_q);
            resp_y     <= q14_scale(raw_y_q);
            resp_theta <= raw_t_q;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
          end
`else
          end else begin
            resp_x     <= eng_xn;
            resp_y     <= eng_yn;
            resp_theta <= eng_thetan;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
          end
`endif
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rot_sched.sv
module tb_cordic_rot_sched;

  localparam int W   = 28;
  localparam int LAT = 34;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int RESP_LAT = LAT + 3;
`else
  localparam int RESP_LAT = LAT + 2;
`endif

  logic           clock = 1'b0;
  logic           Reset = 1'b1;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_x = '0;
  logic [2*W-1:0] req_y = '0;
  logic [2*W-1:0] req_theta = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic           resp_id;
  logic [W-1:0]   resp_x, resp_y, resp_theta;
  logic           eng_start;
  logic [W-1:0]   eng_x0, eng_y0, eng_theta0;
  logic [W-1:0]   eng_xn, eng_yn, eng_thetan;

  int checks = 0;
  int failures = 0;
  logic [3*W:0] sb [$];
  logic         gl [$];
  int           rdy_cnt0 = 0;
  int           rdy_cnt1 = 0;
  logic [3*W:0] mon_exp;

  always #5 clock = ~clock;

  cordic_rot_sched dut (
    .clock      (clock),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_theta  (req_theta),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_x     (resp_x),
    .resp_y     (resp_y),
    .resp_theta (resp_theta),
    .eng_start  (eng_start),
    .eng_x0     (eng_x0),
    .eng_y0     (eng_y0),
    .eng_theta0 (eng_theta0),
    .eng_xn     (eng_xn),
    .eng_yn     (eng_yn),
    .eng_thetan (eng_thetan)
  );

  // Engine stand-in: results only become valid LAT cycles after the start sample.
  logic [W-1:0] e_x_q = '0, e_y_q = '0, e_t_q = '0;
  int           e_cnt = 0;
  always @(posedge clock) begin
    if (eng_start) begin
      e_x_q <= eng_x0;
      e_y_q <= eng_y0;
      e_t_q <= eng_theta0;
      e_cnt <= 1;
    end else if (e_cnt > 0 && e_cnt < 1000) begin
      e_cnt <= e_cnt + 1;
    end
  end
  assign eng_xn     = (e_cnt >= LAT) ? e_y_q + 28'd7        : 28'h0BADBAD;
  assign eng_yn     = (e_cnt >= LAT) ? e_x_q - 28'd11       : 28'h0DEAD01;
  assign eng_thetan = (e_cnt >= LAT) ? e_t_q ^ 28'h0000F0F  : 28'h0C0FFEE;

  function automatic logic [3*W-1:0] prerot_m(input logic signed [W-1:0] x, y, t);
    logic signed [W-1:0] hp, pi;
    hp = 28'sd25736;
    pi = 28'sd51472;
    if (t > hp) return {-x, -y, t - pi};
    if (t < -hp) return {-x, -y, t + pi};
    return {x, y, t};
  endfunction

  function automatic logic [W-1:0] gain_m(input logic [W-1:0] v);
    logic signed [55:0] p;
    p = {{28{v[W-1]}}, v};
    p = p * 56'sd9949;
    return p[41:14];
  endfunction

  function automatic logic [3*W:0] expect_m(input logic id, input logic [W-1:0] x, y, t);
    logic [3*W-1:0] pr;
    logic [W-1:0]   ex, ey, et;
    pr = prerot_m(x, y, t);
    ex = pr[W +: W] + 28'd7;
    ey = pr[2*W +: W] - 28'd11;
    et = pr[0 +: W] ^ 28'h0000F0F;
`ifdef CORDIC_GAIN_COMP_EN
    ex = gain_m(ex);
    ey = gain_m(ey);
`endif
    return {id, ex, ey, et};
  endfunction

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clock) begin
    if (!Reset) begin
      for (int g = 0; g < 2; g++) begin
        if (req_valid[g] && req_ready[g]) begin
          sb.push_back(expect_m(g[0], req_x[g*W +: W], req_y[g*W +: W], req_theta[g*W +: W]));
          gl.push_back(g[0]);
        end
      end
      if (req_ready[0]) rdy_cnt0++;
      if (req_ready[1]) rdy_cnt1++;
      if (resp_valid && resp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: got id=%0d x=%h y=%h t=%h, want no response",
                   resp_id, resp_x, resp_y, resp_theta);
        end else begin
          mon_exp = sb.pop_front();
          if ({resp_id, resp_x, resp_y, resp_theta} !== mon_exp) begin
            failures++;
            $display("FAIL resp_data: got id=%0d x=%h y=%h t=%h, want id=%0d x=%h y=%h t=%h",
                     resp_id, resp_x, resp_y, resp_theta, mon_exp[3*W],
                     mon_exp[2*W +: W], mon_exp[W +: W], mon_exp[0 +: W]);
          end
        end
      end
    end
  end

  task automatic issue(input int id, input logic [W-1:0] x, y, t, output bit ok);
    @(posedge clock); #1;
    req_x[id*W +: W]     = x;
    req_y[id*W +: W]     = y;
    req_theta[id*W +: W] = t;
    req_valid[id]        = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock); #1;
      if (req_ready[id]) ok = 1'b1;
    end
    @(posedge clock); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock); #1;
      n++;
    end while ((sb.size() != 0 || resp_valid) && n < 400);
    checks++;
    if (sb.size() != 0 || resp_valid) begin
      failures++;
      $display("FAIL %s_drain: got %0d results outstanding after %0d cycles, want 0",
               name, sb.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
    end
    checks++;
    if (resp_id !== 1'b0) begin
      failures++; $display("FAIL reset_resp_id: got %b want 0", resp_id);
    end
    checks++;
    if ({resp_x, resp_y, resp_theta} !== '0) begin
      failures++;
      $display("FAIL reset_resp_data: got %h %h %h want 0", resp_x, resp_y, resp_theta);
    end
    checks++;
    if (eng_start !== 1'b0) begin
      failures++; $display("FAIL reset_eng_start: got %b want 0", eng_start);
    end
    checks++;
    if ({eng_x0, eng_y0, eng_theta0} !== '0) begin
      failures++;
      $display("FAIL reset_eng_ops: got %h %h %h want 0", eng_x0, eng_y0, eng_theta0);
    end
    @(posedge clock); #1;
    Reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    gl.delete();
    rdy_cnt0 = 0;
    rdy_cnt1 = 0;
    @(posedge clock); #1;
    req_x     = {28'd3000, 28'd1000};
    req_y     = {28'd4000, 28'd2000};
    req_theta = {28'hFFFFC18, 28'd30000};
    req_valid = 2'b11;
    n = 0;
    while (gl.size() < 4 && n < 400) begin
      @(negedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    req_valid = 2'b00;
    checks++;
    if (gl.size() != 4) begin
      failures++; $display("FAIL b2b_grants: got %0d grants want 4", gl.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gl[i] !== i[0]) begin
          failures++; $display("FAIL b2b_order%0d: got id %b want %b", i, gl[i], i[0]);
        end
      end
    end
    drain("b2b");
    checks++;
    if (rdy_cnt0 != 2 || rdy_cnt1 != 2) begin
      failures++;
      $display("FAIL b2b_ready_cycles: got %0d/%0d want 2/2", rdy_cnt0, rdy_cnt1);
    end
  endtask

  task automatic test_basic0();
    bit ok;
    int lat;
    issue(0, 28'd16384, 28'd0, 28'd25736, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL basic_handshake: got no req_ready[0] want grant");
    end
    @(negedge clock); #1;
    lat = 1;
    checks++;
    if (eng_start !== 1'b1) begin
      failures++; $display("FAIL basic_start: got %b want 1", eng_start);
    end
    checks++;
    if ({eng_x0, eng_y0, eng_theta0} !== {28'd16384, 28'd0, 28'd25736}) begin
      failures++;
      $display("FAIL basic_ops: got %h %h %h want 0004000 0000000 0006488",
               eng_x0, eng_y0, eng_theta0);
    end
    @(negedge clock); #1;
    lat++;
    checks++;
    if (eng_start !== 1'b0) begin
      failures++; $display("FAIL basic_start_pulse: got %b want 0", eng_start);
    end
    while (!resp_valid && lat < 200) begin
      @(negedge clock); #1;
      lat++;
    end
    checks++;
    if (lat != RESP_LAT) begin
      failures++; $display("FAIL basic_latency: got %0d want %0d", lat, RESP_LAT);
    end
    checks++;
    if (resp_id !== 1'b0) begin
      failures++; $display("FAIL basic_id: got %b want 0", resp_id);
    end
    drain("basic");
  endtask

  task automatic test_pi();
    bit ok;
    issue(1, 28'd16384, 28'd0, 28'd51472, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL pi_handshake: got no req_ready[1] want grant");
    end
    @(negedge clock); #1;
    checks++;
    if (eng_start !== 1'b1 || {eng_x0, eng_y0, eng_theta0} !== {28'hFFFC000, 28'd0, 28'd0}) begin
      failures++;
      $display("FAIL pi_ops: got start=%b %h %h %h want 1 FFFC000 0000000 0000000",
               eng_start, eng_x0, eng_y0, eng_theta0);
    end
    drain("pi");
  endtask

  task automatic test_neg();
    bit ok;
    issue(0, 28'd0, 28'd16384, -28'sd40000, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL neg_handshake: got no req_ready[0] want grant");
    end
    @(negedge clock); #1;
    checks++;
    if ({eng_x0, eng_y0, eng_theta0} !== {28'd0, 28'hFFFC000, 28'd11472}) begin
      failures++;
      $display("FAIL neg_ops: got %h %h %h want 0000000 FFFC000 0002CD0",
               eng_x0, eng_y0, eng_theta0);
    end
    drain("neg");
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    int starts;
    logic [3*W:0] snap;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    issue(0, 28'd1234, -28'sd555, 28'd100, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_handshake: got no req_ready[0] want grant");
    end
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      failures++; $display("FAIL bp_resp_timeout: got resp_valid=%b want 1", resp_valid);
    end
    snap = {resp_id, resp_x, resp_y, resp_theta};
    @(posedge clock); #1;
    req_x[W +: W]     = 28'd77;
    req_y[W +: W]     = 28'd88;
    req_theta[W +: W] = 28'd99;
    req_valid[1]      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      checks++;
      if (resp_valid !== 1'b1 || {resp_id, resp_x, resp_y, resp_theta} !== snap ||
          req_ready !== 2'b00 || eng_start !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d: got valid=%b ready=%b start=%b data=%h want 1 00 0 %h",
                 i, resp_valid, req_ready, eng_start,
                 {resp_id, resp_x, resp_y, resp_theta}, snap);
      end
    end
    @(posedge clock); #1;
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    starts = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock); #1;
      if (eng_start) starts++;
    end
    checks++;
    if (starts != 0) begin
      failures++; $display("FAIL bp_dropped_req: got %0d starts want 0", starts);
    end
    drain("bp");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    issue(0, 28'd5000, 28'd6000, 28'd7000, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rst_handshake: got no req_ready[0] want grant");
    end
    repeat (5) begin
      @(negedge clock); #1;
    end
    @(posedge clock); #1;
    Reset = 1'b1;
    @(posedge clock); #1;
    Reset = 1'b0;
    sb.delete();
    @(negedge clock); #1;
    checks++;
    if (resp_valid !== 1'b0 || eng_start !== 1'b0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL rst_after: got valid=%b start=%b ready=%b want 0 0 00",
               resp_valid, eng_start, req_ready);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock); #1;
      if (resp_valid || eng_start) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rst_quiet: got %0d active cycles want 0", bad);
    end
    @(posedge clock); #1;
    req_x     = {28'd9, 28'd8000};
    req_y     = {28'd9, 28'd100};
    req_theta = {28'd9, 28'd40000};
    req_valid = 2'b11;
    @(negedge clock); #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL rst_ptr: got ready=%b want 01", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 2'b00;
    drain("rst");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_basic0();
    test_pi();
    test_neg();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish within time limit, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
